// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA keystream generator XOR-decrypting MSG_LEN ROM bytes into a result RAM; 12 cycles per byte.
// No backpressure: memories are fixed 2-cycle-read slaves, DONE holds until reset.
module prga_decrypt_fsm #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] s_q,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wren,
    output logic       s_rden,
    input  logic [7:0] rom_q,
    output logic [4:0] rom_address,
    output logic [4:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wren,
    output logic       not_complete
);

    typedef enum logic [3:0] {
        IDLE, RD_SI, WT_SI, CP_SI, RD_SJ, WT_SJ, CP_SJ,
        WR_SI, WR_SJ, RD_SF, WT_SF, CP_SF, WR_DEC, DONE
    } state_t;

    localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d;
    logic [7:0] si_val_q, si_val_d, sj_val_q, sj_val_d;
    logic [7:0] f_q, f_d, enc_q, enc_d;
    logic [4:0] k_q, k_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            i_q      <= 8'd0;
            j_q      <= 8'd0;
            k_q      <= 5'd0;
            si_val_q <= 8'd0;
            sj_val_q <= 8'd0;
            f_q      <= 8'd0;
            enc_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            si_val_q <= si_val_d;
            sj_val_q <= sj_val_d;
            f_q      <= f_d;
            enc_q    <= enc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        si_val_d    = si_val_q;
        sj_val_d    = sj_val_q;
        f_d         = f_q;
        enc_d       = enc_q;
        s_address   = 8'd0;
        s_data      = 8'd0;
        s_wren      = 1'b0;
        s_rden      = 1'b0;
        rom_address = 5'd0;
        dec_address = 5'd0;
        dec_data    = 8'd0;
        dec_wren    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_SI;
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = 5'd0;
                end
            end
            // Addresses stay stable through the capture cycle so the read data lines up.
            RD_SI, WT_SI: begin
                s_address = i_q;
                s_rden    = 1'b1;
                state_d   = (state_q == RD_SI) ? WT_SI : CP_SI;
            end
            CP_SI: begin
                s_address = i_q;
                j_d       = j_q + s_q;
                si_val_d  = s_q;
                state_d   = RD_SJ;
            end
            RD_SJ, WT_SJ: begin
                s_address = j_q;
                s_rden    = 1'b1;
                state_d   = (state_q == RD_SJ) ? WT_SJ : CP_SJ;
            end
            CP_SJ: begin
                s_address = j_q;
                sj_val_d  = s_q;
                state_d   = WR_SI;
            end
            WR_SI: begin
                s_address = i_q;
                s_data    = sj_val_q;
                s_wren    = 1'b1;
                state_d   = WR_SJ;
            end
            WR_SJ: begin
                s_address = j_q;
                s_data    = si_val_q;
                s_wren    = 1'b1;
                state_d   = RD_SF;
            end
            // Swapped S[i]+S[j] equals si_val+sj_val, so the pre-swap copies suffice.
            RD_SF, WT_SF: begin
                s_address   = si_val_q + sj_val_q;
                rom_address = k_q;
                s_rden      = 1'b1;
                state_d     = (state_q == RD_SF) ? WT_SF : CP_SF;
            end
            CP_SF: begin
                s_address   = si_val_q + sj_val_q;
                rom_address = k_q;
                f_d         = s_q;
                enc_d       = rom_q;
                state_d     = WR_DEC;
            end
            WR_DEC: begin
                dec_address = k_q;
                dec_data    = f_q ^ enc_q;
                dec_wren    = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 5'd1;
                    i_d     = i_q + 8'd1;
                    state_d = RD_SI;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign not_complete = (state_q != DONE);

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Scoreboarded bench: RC4 PRGA reference model feeds an expected-write queue drained by a negedge monitor.
module tb_prga_decrypt_fsm;

    localparam int MSG = 32;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] s_q;
    logic [7:0] s_address;
    logic [7:0] s_data;
    logic       s_wren;
    logic       s_rden;
    logic [7:0] rom_q;
    logic [4:0] rom_address;
    logic [4:0] dec_address;
    logic [7:0] dec_data;
    logic       dec_wren;
    logic       not_complete;

    prga_decrypt_fsm #(.MSG_LEN(MSG)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_q(s_q), .s_address(s_address), .s_data(s_data),
        .s_wren(s_wren), .s_rden(s_rden),
        .rom_q(rom_q), .rom_address(rom_address),
        .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren),
        .not_complete(not_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with 2-cycle read latency.
    logic [7:0] s_mem [256];
    logic [7:0] rom_mem [MSG];
    logic [7:0] s_p1, rom_p1;
    always @(posedge clk) begin
        if (s_wren) s_mem[s_address] <= s_data;
        s_p1   <= s_mem[s_address];
        s_q    <= s_p1;
        rom_p1 <= rom_mem[rom_address];
        rom_q  <= rom_p1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: RC4 PRGA straight from the algorithm.
    logic [7:0]  ref_s [256];
    logic [12:0] exp_q [$];

    task automatic ref_run();
        logic [7:0] ii, jj, t, idx;
        ii = 8'd0;
        jj = 8'd0;
        for (int n = 0; n < MSG; n++) begin
            ii = ii + 8'd1;
            jj = jj + ref_s[ii];
            t = ref_s[ii];
            ref_s[ii] = ref_s[jj];
            ref_s[jj] = t;
            idx = ref_s[ii] + ref_s[jj];
            exp_q.push_back({5'(n), ref_s[idx] ^ rom_mem[n]});
        end
    endtask

    // Monitor / scoreboard
    int          edge_cnt = 0;
    int          e0_edge = 0;
    bit          mon_en = 0;
    int          s_wr_cnt, rd_cnt, dec_cnt, first_dec_cyc, nc_fall_cyc;
    logic [7:0]  obs [MSG];
    logic [12:0] e;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        int cyc;
        if (mon_en) begin
            cyc = edge_cnt - e0_edge + 1;
            if (s_wren) s_wr_cnt++;
            if (s_rden) rd_cnt++;
            if (dec_wren) begin
                dec_cnt++;
                if (first_dec_cyc < 0) first_dec_cyc = cyc;
                obs[dec_address] = dec_data;
                if (exp_q.size() == 0) begin
                    check("unexpected_dec_wren", {19'd0, dec_address, dec_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_write", {19'd0, dec_address, dec_data}, {19'd0, e});
                end
            end
            if (!not_complete && nc_fall_cyc < 0) nc_fall_cyc = cyc;
        end
    end

    task automatic clear_counts();
        s_wr_cnt = 0;
        rd_cnt = 0;
        dec_cnt = 0;
        first_dec_cyc = -1;
        nc_fall_cyc = -1;
    endtask

    task automatic load_identity(input logic [7:0] enc0);
        for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
        for (int x = 0; x < MSG; x++) rom_mem[x] = 8'h00;
        rom_mem[0] = enc0;
    endtask

    task automatic load_random();
        logic [7:0] t;
        int r;
        for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = s_mem[x];
            s_mem[x] = s_mem[r];
            s_mem[r] = t;
        end
        for (int x = 0; x < MSG; x++) rom_mem[x] = 8'($urandom);
    endtask

    task automatic do_reset();
        mon_en = 0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_msg(input bit pulse);
        for (int x = 0; x < 256; x++) ref_s[x] = s_mem[x];
        ref_run();
        clear_counts();
        for (int x = 0; x < MSG; x++) obs[x] = 8'hxx;
        @(negedge clk);
        mon_en = 1;
        start = 1'b1;
        e0_edge = edge_cnt + 1;
        if (pulse) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        int bad = 0;
        while (nc_fall_cyc < 0 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_done_timeout"}, {31'd0, nc_fall_cyc < 0}, 32'd0);
        check({tag, "_first_dec_cycle"}, first_dec_cyc, 32'd12);
        check({tag, "_nc_fall_cycle"}, nc_fall_cyc, 32'(12 * MSG + 1));
        check({tag, "_dec_wren_count"}, dec_cnt, 32'(MSG));
        check({tag, "_s_wren_count"}, s_wr_cnt, 32'(2 * MSG));
        check({tag, "_s_rden_count"}, rd_cnt, 32'(6 * MSG));
        check({tag, "_queue_left"}, exp_q.size(), 32'd0);
        for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) bad++;
        check({tag, "_final_s_mismatches"}, bad, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_address"}, {24'd0, s_address}, 32'd0);
        check({tag, "_s_data"}, {24'd0, s_data}, 32'd0);
        check({tag, "_strobes"}, {29'd0, s_wren, s_rden, dec_wren}, 32'd0);
        check({tag, "_rom_dec_addr"}, {22'd0, rom_address, dec_address}, 32'd0);
        check({tag, "_dec_data"}, {24'd0, dec_data}, 32'd0);
        check({tag, "_not_complete"}, {31'd0, not_complete}, 32'd1);
    endtask

    initial begin
        int nc_hi;
        start = 1'b0;
        reset = 1'b1;
        clear_counts();
        load_identity(8'h00);
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset_held");

        // Idle with start low: no memory traffic.
        reset = 1'b1;
        clear_counts();
        mon_en = 1;
        repeat (20) @(negedge clk);
        #1;
        check("idle_activity", s_wr_cnt + rd_cnt + dec_cnt, 32'd0);

        // Identity S, zero ciphertext, start held high throughout.
        start_msg(1'b0);
        wait_done("ident");
        check("ident_dec0", {24'd0, obs[0]}, 32'h02);
        check("ident_dec1", {24'd0, obs[1]}, 32'h05);

        // DONE is sticky with start still asserted.
        clear_counts();
        nc_hi = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (not_complete) nc_hi++;
        end
        check("sticky_writes", s_wr_cnt + dec_cnt + rd_cnt, 32'd0);
        check("sticky_not_complete_high", nc_hi, 32'd0);
        start = 1'b0;

        // enc[0] = 0xFF
        do_reset();
        load_identity(8'hFF);
        start_msg(1'b1);
        wait_done("encff");
        check("encff_dec0", {24'd0, obs[0]}, 32'hFD);

        // Random permutations and ciphertext, start pulsed for one cycle.
        for (int t = 0; t < 3; t++) begin
            do_reset();
            load_random();
            start_msg(1'b1);
            wait_done($sformatf("rand%0d", t));
        end

        // Reset in the middle of a message, then rerun.
        do_reset();
        load_identity(8'h00);
        start_msg(1'b1);
        repeat (48) @(negedge clk);
        mon_en = 0;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        load_identity(8'h00);
        start_msg(1'b1);
        wait_done("rerun");
        check("rerun_dec0", {24'd0, obs[0]}, 32'h02);
        check("rerun_dec1", {24'd0, obs[1]}, 32'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prga_decrypt_fsm.md
PRGA_DECRYPT_FSM -- requirements
Module: prga_decrypt_fsm

Interface
REQ-001 Parameter: MSG_LEN, default 32, number of message bytes decrypted (legal range 1..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; sampled in IDLE, 1 = begin decryption (S array already initialized and shuffled).
REQ-005 s_q  input  8  read data from S memory.
REQ-006 s_address  output  8  S memory address.
REQ-007 s_data  output  8  S memory write data.
REQ-008 s_wren  output  1  S memory write enable.
REQ-009 s_rden  output  1  S memory read enable.
REQ-010 rom_q  input  8  encrypted-message ROM read data.
REQ-011 rom_address  output  5  encrypted-message ROM address.
REQ-012 dec_address  output  5  decrypted-message RAM address.
REQ-013 dec_data  output  8  decrypted-message RAM write data.
REQ-014 dec_wren  output  1  decrypted-message RAM write enable.
REQ-015 not_complete  output  1  1 until all MSG_LEN bytes are written, then 0.

Function
REQ-016 The block SHALL compute, for k = 0..MSG_LEN-1: i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[(S[i]+S[j]) mod 256]; dec[k]=f XOR enc[k]; with i=j=0 at start.
REQ-017 All i, j and index sums SHALL be 8-bit, wrapping mod 256.
REQ-018 Memory reads (S and ROM) SHALL be treated as 2-cycle latency: address/rden driven in issue cycle A, data captured at the end of cycle A+2.
REQ-019 States: IDLE, RD_SI, WT_SI, CP_SI, RD_SJ, WT_SJ, CP_SJ, WR_SI, WR_SJ, RD_SF, WT_SF, CP_SF, WR_DEC, DONE; each state lasts exactly one cycle.
REQ-020 IDLE -> RD_SI when start=1 (i becomes 1 on that edge); otherwise remain in IDLE.
REQ-021 RD_SI..CP_SI: read S[i]; at CP_SI, j <= j + s_q and si_val <= s_q.
REQ-022 RD_SJ..CP_SJ: read S[j]; at CP_SJ, sj_val <= s_q.
REQ-023 WR_SI: s_address=i, s_data=sj_val, s_wren=1; WR_SJ: s_address=j, s_data=si_val, s_wren=1.
REQ-024 RD_SF..CP_SF: s_address=(si_val+sj_val) mod 256 and rom_address=k, held for all three cycles; at CP_SF capture f and enc byte.
REQ-025 WR_DEC: dec_address=k, dec_data=f XOR enc, dec_wren=1; then k=k+1, i=i+1 and go to RD_SJ-equivalent start of next byte (RD_SI) if k+1 < MSG_LEN, else DONE.
REQ-026 Per byte SHALL take exactly 12 cycles; with start accepted at edge E0, byte k's WR_DEC occupies cycle 12k+12, and not_complete SHALL be 0 from cycle 12*MSG_LEN+1.
REQ-027 s_rden SHALL be 1 only in RD_* and WT_* states; s_wren only in WR_SI/WR_SJ; dec_wren only in WR_DEC.
REQ-028 i == j SHALL be handled without special casing (both writes store the same value; S unchanged).
REQ-029 DONE SHALL be sticky: start held or re-asserted SHALL NOT restart; no further memory writes until reset.
REQ-030 start deasserting after acceptance SHALL NOT affect an operation in progress.

Reset
REQ-031 On reset=0, asynchronously: state=IDLE, i=j=k=0, si_val=sj_val=f=enc=0, all addresses/data 0, s_wren=s_rden=dec_wren=0, not_complete=1.
REQ-032 Reset mid-operation SHALL abandon the message; after release, the block waits in IDLE for start.

Verification
REQ-033 Hold reset=0 -> all outputs 0, not_complete=1; release with start=0 for 20 cycles -> no wren/rden activity.
REQ-034 S[x]=x, enc all 0x00, MSG_LEN=32 -> dec[0]=0x02 (i=j=1 case), dec[1]=0x05, S[2]=0x03, S[3]=0x02 after byte 1.
REQ-035 Same setup, enc[0]=0xFF -> dec[0]=0xFD.
REQ-036 start accepted at E0 -> first dec_wren in cycle 12 with dec_address=0; not_complete falls at cycle 385; exactly 32 dec_wren pulses and 64 s_wren pulses.
REQ-037 Keep start=1 for 100 cycles after DONE -> zero writes, not_complete stays 0.
REQ-038 Assert reset at cycle 50, reload S[x]=x, restart -> outputs return to reset values immediately; rerun yields dec[0]=0x02, dec[1]=0x05.
